// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract unit computing a WIDTH-bit
// result CHUNK bits per clock, carry held in a register between chunks.
// Valid/ready handshakes on the operand and result sides.
// Optional feature macro: CHUNKED_ADDER_BACK2BACK_EN -- when defined, DONE can
// retire a result and accept new operands on the same edge (DONE -> RUN).
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      chunk_base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic             rdy;
    logic             load;

    // Chunk datapath: add the current slice of A and Bx plus the held carry
    always_comb begin
        chunk_base = 32'(idx_q) * 32'(CHUNK);
        a_chunk    = a_q[chunk_base +: CHUNK];
        b_chunk    = bx_q[chunk_base +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from the sum bit
        msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    // Next-state, handshake outputs and register updates
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        bx_d      = bx_q;
        s_d       = s_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        rdy       = 1'b0;
        load      = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                rdy  = 1'b1;
                load = in_valid;
            end
            RUN: begin
                s_d[chunk_base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_cin ^ chunk_sum[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef CHUNKED_ADDER_BACK2BACK_EN
                rdy = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                    load    = in_valid;
                end
`else
                if (out_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Subtraction is A + ~B + ~Cin; inversion happens once at accept
        if (load) begin
            a_d     = A;
            bx_d    = Sub ? ~B : B;
            carry_d = Sub ? ~Cin : Cin;
            idx_d   = '0;
            state_d = RUN;
        end

        in_ready = rdy & rst_n;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder (WIDTH=16, CHUNK=4 and CHUNK=16).
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [15:0] A, B;
    logic        Cin, Sub;
    logic        in_ready, out_valid;
    logic [15:0] S;
    logic        Cout, Ovf;

    logic        in_valid2, out_ready2;
    logic        in_ready2, out_valid2;
    logic [15:0] S2;
    logic        Cout2, Ovf2;

    int checks   = 0;
    int failures = 0;

`ifdef CHUNKED_ADDER_BACK2BACK_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .S(S2), .Cout(Cout2), .Ovf(Ovf2)
    );

    // Reference: plain integer arithmetic, returns {ovf, cout, s}
    function automatic logic [17:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        logic [16:0] t;
        int          r;
        logic        c, o;
        if (sub) begin
            t = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            c = ~t[16];
            r = int'($signed(a)) - int'($signed(b)) - int'(cin);
        end else begin
            t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            c = t[16];
            r = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        o = (r > 32767) || (r < -32768);
        return {o, c, t[15:0]};
    endfunction

    // Drive one operation on the CHUNK=4 instance; lat = edges from accept to out_valid, -1 on timeout
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic rdy, output int lat);
        int n;
        A = a; B = b; Cin = cin; Sub = sub; out_ready = rdy; in_valid = 1'b1;
        lat = -1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (out_valid) lat = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
        A = 16'h0; B = 16'h0; Cin = 1'b0; Sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (S !== 16'h0000) begin failures++; $display("FAIL reset_S: got %h expected 0000", S); end
        checks++; if ({Cout, Ovf} !== 2'b00) begin failures++; $display("FAIL reset_cout_ovf: got %b expected 00", {Cout, Ovf}); end
        checks++; if (in_ready2 !== 1'b0) begin failures++; $display("FAIL reset_in_ready_c16: got %b expected 0", in_ready2); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_add_wrap();
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL add_wrap_latency: got %0d expected 4", lat); end
        checks++; if (S !== 16'h0000) begin failures++; $display("FAIL add_wrap_S: got %h expected 0000", S); end
        checks++; if (Cout !== 1'b1) begin failures++; $display("FAIL add_wrap_Cout: got %b expected 1", Cout); end
        checks++; if (Ovf !== 1'b0) begin failures++; $display("FAIL add_wrap_Ovf: got %b expected 0", Ovf); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_wrap_retire: got %b expected 0", out_valid); end
    endtask

    task automatic test_sub_borrow();
        int lat;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sub1_latency: got %0d expected 4", lat); end
        checks++; if ({Ovf, Cout, S} !== {1'b0, 1'b0, 16'hFFFE}) begin failures++; $display("FAIL sub1_result: got ovf=%b cout=%b S=%h expected ovf=0 cout=0 S=fffe", Ovf, Cout, S); end
        @(posedge clk); #1;
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, lat);
        checks++; if ({Ovf, Cout, S} !== {1'b0, 1'b1, 16'h0001}) begin failures++; $display("FAIL sub2_result: got ovf=%b cout=%b S=%h expected ovf=0 cout=1 S=0001", Ovf, Cout, S); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, lat);
        checks++; if ({Ovf, Cout, S} !== {1'b1, 1'b0, 16'h8000}) begin failures++; $display("FAIL ovf_add: got ovf=%b cout=%b S=%h expected ovf=1 cout=0 S=8000", Ovf, Cout, S); end
        @(posedge clk); #1;
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, lat);
        checks++; if ({Ovf, Cout, S} !== {1'b1, 1'b1, 16'h7FFF}) begin failures++; $display("FAIL ovf_sub: got ovf=%b cout=%b S=%h expected ovf=1 cout=1 S=7fff", Ovf, Cout, S); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int  lat;
        logic stable_ok, rdy_ok, val_ok;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        stable_ok = 1'b1; rdy_ok = 1'b1; val_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            A = 16'($urandom); B = 16'($urandom); Sub = ~Sub; Cin = ~Cin;
            @(posedge clk); #1;
            if ({Ovf, Cout, S} !== {1'b0, 1'b0, 16'h5555}) stable_ok = 1'b0;
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
            if (out_valid !== 1'b1) val_ok = 1'b0;
        end
        checks++; if (!stable_ok) begin failures++; $display("FAIL bp_hold: got ovf=%b cout=%b S=%h expected ovf=0 cout=0 S=5555", Ovf, Cout, S); end
        checks++; if (!rdy_ok) begin failures++; $display("FAIL bp_in_ready: got %b expected 0 throughout", in_ready); end
        checks++; if (!val_ok) begin failures++; $display("FAIL bp_out_valid: got %b expected 1 throughout", out_valid); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_retire_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_retire_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int   lat;
        logic seen_valid;
        out_ready = 1'b1;
        A = 16'h1234; B = 16'h1111; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if ({Ovf, Cout, S} !== 18'h0) begin failures++; $display("FAIL midrst_outputs: got ovf=%b cout=%b S=%h expected zeros", Ovf, Cout, S); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release_ready: got %b expected 1", in_ready); end
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_result: got %b expected 0", seen_valid); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL midrst_next_latency: got %0d expected 4", lat); end
        checks++; if (S !== 16'h0002) begin failures++; $display("FAIL midrst_next_S: got %h expected 0002", S); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input bit wide, input int nops);
        logic [17:0] exp_q[$];
        logic [17:0] exp_v, got_v;
        int accepted, retired, cyc, last_acc, period;
        logic fire_in, fire_out, cur_ir, cur_ov;
        period   = (wide ? 1 : 4) + GAP;
        accepted = 0; retired = 0; cyc = 0; last_acc = -1;
        A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
        if (wide) begin in_valid2 = 1'b1; out_ready2 = 1'b1; end
        else begin in_valid = 1'b1; out_ready = 1'b1; end
        while (retired < nops && cyc < nops * 8 + 50) begin
            cur_ir = wide ? in_ready2 : in_ready;
            cur_ov = wide ? out_valid2 : out_valid;
            got_v  = wide ? {Ovf2, Cout2, S2} : {Ovf, Cout, S};
            fire_in  = (accepted < nops) && cur_ir;
            fire_out = cur_ov;
            if (fire_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_result: got %h expected none (wide=%0d)", got_v, wide);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        failures++; $display("FAIL b2b_result: got %h expected %h (op %0d wide=%0d)", got_v, exp_v, retired, wide);
                    end
                end
                retired++;
            end
            if (fire_in) begin
                exp_q.push_back(ref_calc(A, B, Cin, Sub));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== period) begin
                        failures++; $display("FAIL b2b_spacing: got %0d expected %0d (wide=%0d)", cyc - last_acc, period, wide);
                    end
                end
                last_acc = cyc;
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire_in) begin
                A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
                if (accepted == nops) begin
                    if (wide) in_valid2 = 1'b0; else in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; in_valid2 = 1'b0;
        checks++; if (retired !== nops) begin failures++; $display("FAIL b2b_count: got %0d expected %0d (wide=%0d)", retired, nops, wide); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_borrow();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back(1'b0, 100);
        test_back_to_back(1'b1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
